dnn_sample_scheduler: RTL and testbench

// Front-end sequencer for the DNN datapath. Accepts 4-feature samples from an upstream

---
 rtl/dnn_sample_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_dnn_sample_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_sample_scheduler.sv
// Sample buffer and issue sequencer for the DNN input layer: issue_* is registered, earliest one edge after the push.
// Backpressure: s_ready drops on full FIFO or flush; issue stalls on the spacing gap or the in-flight cap.
module dnn_sample_scheduler #(
    parameter int IN_W         = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int ISSUE_GAP    = 1,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [IN_W-1:0] s_in0,
    input  logic [IN_W-1:0] s_in1,
    input  logic [IN_W-1:0] s_in2,
    input  logic [IN_W-1:0] s_in3,
    output logic            issue_valid,
    output logic [IN_W-1:0] issue0,
    output logic [IN_W-1:0] issue1,
    output logic [IN_W-1:0] issue2,
    output logic [IN_W-1:0] issue3,
    input  logic            res_valid,
    input  logic            flush,
    output logic [3:0]      inflight,
    output logic [15:0]     res_count,
    output logic            busy,
    output logic            err_underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = 4 * IN_W;
    localparam int GW = $clog2(ISSUE_GAP + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH_WAIT,
        ST_FLUSH_CLR
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SW-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [GW-1:0]   r_gap;
    logic [3:0]      r_inflight;
    logic [15:0]     r_res_count;
    logic            r_err;
    logic            r_issue_valid;
    logic [SW-1:0]   r_issue_dat;

    logic            w_full;
    logic            w_empty;
    logic            w_flushing;
    logic            w_push;
    logic            w_issue;
    logic            w_res_acc;
    logic            w_underflow;
    logic            w_fifo_clr;

    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_flushing = (r_state == ST_FLUSH_WAIT) || (r_state == ST_FLUSH_CLR);

    // flush gates s_ready combinationally so a push in the flush cycle is dropped
    assign s_ready = !w_full && !w_flushing && !flush;
    assign w_push  = s_valid && s_ready;

    assign w_issue = !w_empty && (r_gap == '0) && (r_inflight < 4'(MAX_INFLIGHT))
                     && (r_state == ST_RUN) && !flush;

    // a result returning in the same cycle as an issue is covered by that issue
    assign w_res_acc   = res_valid && ((r_inflight != 4'd0) || w_issue);
    assign w_underflow = res_valid && (r_inflight == 4'd0) && !w_issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fifo_clr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (flush) begin
                    w_state_nxt = ST_FLUSH_WAIT;
                end else if (!w_empty || s_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    w_state_nxt = ST_FLUSH_WAIT;
                end else if (w_empty && (r_inflight == 4'd0) && !w_push) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FLUSH_WAIT: begin
                if (r_inflight == 4'd0) begin
                    w_state_nxt = ST_FLUSH_CLR;
                end
            end
            ST_FLUSH_CLR: begin
                w_fifo_clr  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_in3, s_in2, s_in1, s_in0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_fifo_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap <= '0;
        end else if (w_fifo_clr) begin
            r_gap <= '0;
        end else if (w_issue) begin
            r_gap <= GW'(ISSUE_GAP - 1);
        end else if (r_gap != '0) begin
            r_gap <= r_gap - GW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight  <= 4'd0;
            r_res_count <= 16'd0;
            r_err       <= 1'b0;
        end else begin
            case ({w_issue, w_res_acc})
                2'b10:   r_inflight <= r_inflight + 4'd1;
                2'b01:   r_inflight <= r_inflight - 4'd1;
                default: r_inflight <= r_inflight;
            endcase
            if (w_res_acc) begin
                r_res_count <= r_res_count + 16'd1;
            end
            if (w_underflow) begin
                r_err <= 1'b1;
            end
        end
    end

    // issue data is forced to zero on idle cycles so the layer never sees stale features
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_valid <= 1'b0;
            r_issue_dat   <= '0;
        end else begin
            r_issue_valid <= w_issue;
            r_issue_dat   <= w_issue ? r_mem[r_rd_ptr] : '0;
        end
    end

    assign issue_valid   = r_issue_valid;
    assign issue0        = r_issue_dat[IN_W-1:0];
    assign issue1        = r_issue_dat[2*IN_W-1:IN_W];
    assign issue2        = r_issue_dat[3*IN_W-1:2*IN_W];
    assign issue3        = r_issue_dat[4*IN_W-1:3*IN_W];
    assign inflight      = r_inflight;
    assign res_count     = r_res_count;
    assign busy          = (r_state != ST_IDLE);
    assign err_underflow = r_err;

endmodule

// File: tb/tb_dnn_sample_scheduler.sv
// Bench: instance A (gap 1, cap 4) and instance B (gap 3, cap 2) share stimulus; each is checked
// cycle by cycle against a queue-based model, plus a vector table and directed corner sequences.
module tb_dnn_sample_scheduler;

    localparam int DEPTH = 4;
    localparam int GAPV [2] = '{1, 3};
    localparam int MAXV [2] = '{4, 2};

    logic       clk;
    logic       rst_n;
    logic       s_valid;
    logic [4:0] s_in0, s_in1, s_in2, s_in3;
    logic       res_valid;
    logic       flush;

    logic       a_s_ready, a_iv, a_busy, a_err;
    logic [4:0] a_i0, a_i1, a_i2, a_i3;
    logic [3:0] a_inf;
    logic [15:0] a_rc;
    logic       b_s_ready, b_iv, b_busy, b_err;
    logic [4:0] b_i0, b_i1, b_i2, b_i3;
    logic [3:0] b_inf;
    logic [15:0] b_rc;

    dnn_sample_scheduler #(.IN_W(5), .FIFO_DEPTH(DEPTH), .ISSUE_GAP(1), .MAX_INFLIGHT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(a_s_ready),
        .s_in0(s_in0), .s_in1(s_in1), .s_in2(s_in2), .s_in3(s_in3),
        .issue_valid(a_iv), .issue0(a_i0), .issue1(a_i1), .issue2(a_i2), .issue3(a_i3),
        .res_valid(res_valid), .flush(flush), .inflight(a_inf), .res_count(a_rc),
        .busy(a_busy), .err_underflow(a_err)
    );

    dnn_sample_scheduler #(.IN_W(5), .FIFO_DEPTH(DEPTH), .ISSUE_GAP(3), .MAX_INFLIGHT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(b_s_ready),
        .s_in0(s_in0), .s_in1(s_in1), .s_in2(s_in2), .s_in3(s_in3),
        .issue_valid(b_iv), .issue0(b_i0), .issue1(b_i1), .issue2(b_i2), .issue3(b_i3),
        .res_valid(res_valid), .flush(flush), .inflight(b_inf), .res_count(b_rc),
        .busy(b_busy), .err_underflow(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        act_rdy  [2];
    logic        act_iv   [2];
    logic [19:0] act_dat  [2];
    logic [3:0]  act_inf  [2];
    logic [15:0] act_rc   [2];
    logic        act_busy [2];
    logic        act_err  [2];

    assign act_rdy[0]  = a_s_ready;
    assign act_rdy[1]  = b_s_ready;
    assign act_iv[0]   = a_iv;
    assign act_iv[1]   = b_iv;
    assign act_dat[0]  = {a_i3, a_i2, a_i1, a_i0};
    assign act_dat[1]  = {b_i3, b_i2, b_i1, b_i0};
    assign act_inf[0]  = a_inf;
    assign act_inf[1]  = b_inf;
    assign act_rc[0]   = a_rc;
    assign act_rc[1]   = b_rc;
    assign act_busy[0] = a_busy;
    assign act_busy[1] = b_busy;
    assign act_err[0]  = a_err;
    assign act_err[1]  = b_err;

    int n_checks = 0;
    int n_errors = 0;

    // model: modes 0 idle, 1 run, 2 waiting for results to drain, 3 clearing
    logic [19:0] mq0 [$];
    logic [19:0] mq1 [$];
    int          m_infl [2];
    int          m_gap  [2];
    int          m_mode [2];
    logic [15:0] m_rc   [2];
    bit          m_err  [2];
    bit          m_iv   [2];
    logic [19:0] m_idat [2];
    logic        pre_rdy [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] pk(input int d0, input int d1, input int d2, input int d3);
        return {5'(d3), 5'(d2), 5'(d1), 5'(d0)};
    endfunction

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        for (int k = 0; k < 2; k++) begin
            m_infl[k] = 0; m_gap[k] = 0; m_mode[k] = 0;
            m_rc[k] = 16'd0; m_err[k] = 1'b0; m_iv[k] = 1'b0; m_idat[k] = 20'd0;
        end
    endtask

    task automatic model_step(input int k, input bit sv, input logic [19:0] d,
                              input bit rv, input bit fl, output bit rdy);
        logic [19:0] q [$];
        int  sz, infl_pre, mode_pre;
        bit  push, iss, acc;
        if (k == 0) q = mq0; else q = mq1;
        sz       = q.size();
        infl_pre = m_infl[k];
        mode_pre = m_mode[k];
        rdy  = (sz < DEPTH) && (mode_pre < 2) && !fl;
        push = sv && rdy;
        iss  = (sz > 0) && (m_gap[k] == 0) && (infl_pre < MAXV[k]) && (mode_pre == 1) && !fl;
        acc  = rv && ((infl_pre > 0) || iss);
        m_iv[k]   = iss;
        m_idat[k] = 20'd0;
        if (iss) m_idat[k] = q.pop_front();
        if (acc) m_rc[k] = m_rc[k] + 16'd1;
        if (rv && !acc) m_err[k] = 1'b1;
        m_infl[k] = infl_pre + int'(iss) - int'(acc);
        if (iss) m_gap[k] = GAPV[k] - 1;
        else if (m_gap[k] > 0) m_gap[k] = m_gap[k] - 1;
        if (push) q.push_back(d);
        case (mode_pre)
            0: if (fl) m_mode[k] = 2; else if (sz > 0 || sv) m_mode[k] = 1;
            1: if (fl) m_mode[k] = 2; else if (sz == 0 && infl_pre == 0 && !push) m_mode[k] = 0;
            2: if (infl_pre == 0) m_mode[k] = 3;
            default: begin q.delete(); m_gap[k] = 0; m_mode[k] = 0; end
        endcase
        if (k == 0) mq0 = q; else mq1 = q;
    endtask

    // one clock: drive, check s_ready and the model before the edge, check outputs after it
    task automatic step(input bit sv, input logic [19:0] d, input bit rv, input bit fl);
        bit r;
        string p;
        s_valid = sv;
        {s_in3, s_in2, s_in1, s_in0} = d;
        res_valid = rv;
        flush = fl;
        #1;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? "A" : "B";
            model_step(k, sv, d, rv, fl, r);
            pre_rdy[k] = act_rdy[k];
            chk({p, ".s_ready"}, 32'(act_rdy[k]), 32'(r));
        end
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        res_valid = 1'b0;
        flush = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? "A" : "B";
            chk({p, ".issue_valid"}, 32'(act_iv[k]), 32'(m_iv[k]));
            chk({p, ".issue_data"}, 32'(act_dat[k]), 32'(m_idat[k]));
            chk({p, ".inflight"}, 32'(act_inf[k]), 32'(m_infl[k]));
            chk({p, ".res_count"}, 32'(act_rc[k]), 32'(m_rc[k]));
            chk({p, ".err_underflow"}, 32'(act_err[k]), 32'(m_err[k]));
            chk({p, ".busy"}, 32'(act_busy[k]), 32'(m_mode[k] != 0));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 20'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        string p;
        s_valid = 1'b0; res_valid = 1'b0; flush = 1'b0;
        rst_n = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? "A" : "B";
            chk({p, ".rst_issue_valid"}, 32'(act_iv[k]), 32'd0);
            chk({p, ".rst_issue_data"}, 32'(act_dat[k]), 32'd0);
            chk({p, ".rst_inflight"}, 32'(act_inf[k]), 32'd0);
            chk({p, ".rst_res_count"}, 32'(act_rc[k]), 32'd0);
            chk({p, ".rst_err"}, 32'(act_err[k]), 32'd0);
            chk({p, ".rst_busy"}, 32'(act_busy[k]), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? "A" : "B";
            chk({p, ".rst_release_s_ready"}, 32'(act_rdy[k]), 32'd1);
        end
        model_reset();
    endtask

    typedef struct {
        bit          sv;
        logic [19:0] d;
        bit          rv;
        bit          rdy;
        bit          iv;
        logic [19:0] dat;
        logic [3:0]  inf;
        logic [15:0] rc;
        bit          err;
        bit          busy;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int n_iss;
        logic [19:0] s1, s2, s3, sx;
        rst_n = 1'b0; s_valid = 1'b0; res_valid = 1'b0; flush = 1'b0;
        {s_in3, s_in2, s_in1, s_in0} = 20'd0;
        model_reset();

        // instance A expectations: back-to-back issue, result/issue overlap, underflow stickiness
        tbl[0]  = '{1, pk(1, -2, 3, -4),   0, 1, 0, 20'd0,              0, 0, 0, 1};
        tbl[1]  = '{1, pk(5, 6, 7, -8),    0, 1, 1, pk(1, -2, 3, -4),   1, 0, 0, 1};
        tbl[2]  = '{0, 20'd0,              0, 1, 1, pk(5, 6, 7, -8),    2, 0, 0, 1};
        tbl[3]  = '{0, 20'd0,              1, 1, 0, 20'd0,              1, 1, 0, 1};
        tbl[4]  = '{1, pk(-16, 15, 0, -1), 1, 1, 0, 20'd0,              0, 2, 0, 1};
        tbl[5]  = '{0, 20'd0,              1, 1, 1, pk(-16, 15, 0, -1), 0, 3, 0, 1};
        tbl[6]  = '{0, 20'd0,              1, 1, 0, 20'd0,              0, 3, 1, 0};
        tbl[7]  = '{0, 20'd0,              0, 1, 0, 20'd0,              0, 3, 1, 0};
        tbl[8]  = '{0, 20'd0,              1, 1, 0, 20'd0,              0, 3, 1, 0};
        tbl[9]  = '{1, pk(2, 2, 2, 2),     0, 1, 0, 20'd0,              0, 3, 1, 1};
        tbl[10] = '{0, 20'd0,              0, 1, 1, pk(2, 2, 2, 2),     1, 3, 1, 1};
        tbl[11] = '{1, pk(3, 3, 3, 3),     0, 1, 0, 20'd0,              1, 3, 1, 1};
        tbl[12] = '{0, 20'd0,              1, 1, 1, pk(3, 3, 3, 3),     1, 4, 1, 1};
        tbl[13] = '{0, 20'd0,              1, 1, 0, 20'd0,              0, 5, 1, 1};
        tbl[14] = '{0, 20'd0,              0, 1, 0, 20'd0,              0, 5, 1, 0};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].sv, tbl[i].d, tbl[i].rv, 1'b0);
            chk($sformatf("tbl%0d.s_ready", i), 32'(pre_rdy[0]), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d.issue_valid", i), 32'(a_iv), 32'(tbl[i].iv));
            chk($sformatf("tbl%0d.issue_data", i), 32'({a_i3, a_i2, a_i1, a_i0}), 32'(tbl[i].dat));
            chk($sformatf("tbl%0d.inflight", i), 32'(a_inf), 32'(tbl[i].inf));
            chk($sformatf("tbl%0d.res_count", i), 32'(a_rc), 32'(tbl[i].rc));
            chk($sformatf("tbl%0d.err", i), 32'(a_err), 32'(tbl[i].err));
            chk($sformatf("tbl%0d.busy", i), 32'(a_busy), 32'(tbl[i].busy));
        end

        // reset mid-operation: B holds 3 queued and 2 in flight
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, pk(i, -i, i + 1, 7), 1'b0, 1'b0);
        idle(4);
        chk("mid.B_inflight", 32'(b_inf), 32'd2);
        chk("mid.B_busy", 32'(b_busy), 32'd1);
        do_reset();

        // spacing of 3 on B: pulses at steps 1, 4, 7 with zero data between
        s1 = pk(1, 2, 3, 4); s2 = pk(-1, -2, -3, -4); s3 = pk(9, -9, 15, -16);
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: step(1'b1, s1, 1'b0, 1'b0);
                1: step(1'b1, s2, 1'b0, 1'b0);
                2: step(1'b1, s3, 1'b1, 1'b0);
                default: step(1'b0, 20'd0, 1'b0, 1'b0);
            endcase
            chk($sformatf("gap.step%0d.B_issue_valid", i), 32'(b_iv),
                32'((i == 1) || (i == 4) || (i == 7)));
            case (i)
                1: chk("gap.B_data1", 32'({b_i3, b_i2, b_i1, b_i0}), 32'(s1));
                4: chk("gap.B_data2", 32'({b_i3, b_i2, b_i1, b_i0}), 32'(s2));
                7: chk("gap.B_data3", 32'({b_i3, b_i2, b_i1, b_i0}), 32'(s3));
                default: chk($sformatf("gap.step%0d.B_zero", i), 32'({b_i3, b_i2, b_i1, b_i0}), 32'd0);
            endcase
        end
        step(1'b0, 20'd0, 1'b1, 1'b0);
        step(1'b0, 20'd0, 1'b1, 1'b0);

        // in-flight cap of 2 on B, then fill and flush
        do_reset();
        n_iss = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 4) step(1'b1, pk(i + 1, i + 2, i + 3, i + 4), 1'b0, 1'b0);
            else idle(1);
            n_iss += int'(b_iv);
        end
        chk("cap.B_issues_stalled", 32'(n_iss), 32'd2);
        chk("cap.B_inflight", 32'(b_inf), 32'd2);
        step(1'b0, 20'd0, 1'b1, 1'b0);
        n_iss += int'(b_iv);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            n_iss += int'(b_iv);
        end
        chk("cap.B_issues_after_result", 32'(n_iss), 32'd3);
        chk("cap.B_res_count", 32'(b_rc), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, pk(-5, -6, -7, -8), 1'b0, 1'b0);
        chk("flush.B_full_s_ready", 32'(b_s_ready), 32'd0);
        step(1'b1, pk(4, 4, 4, 4), 1'b0, 1'b1);
        chk("flush.B_busy_wait", 32'(b_busy), 32'd1);
        chk("flush.B_s_ready_wait", 32'(b_s_ready), 32'd0);
        step(1'b0, 20'd0, 1'b1, 1'b0);
        chk("flush.B_inflight1", 32'(b_inf), 32'd1);
        step(1'b0, 20'd0, 1'b1, 1'b0);
        chk("flush.B_inflight0", 32'(b_inf), 32'd0);
        chk("flush.B_busy_still", 32'(b_busy), 32'd1);
        idle(1);
        chk("flush.B_busy_clr", 32'(b_busy), 32'd1);
        idle(1);
        chk("flush.B_idle", 32'(b_busy), 32'd0);
        chk("flush.B_s_ready_after", 32'(b_s_ready), 32'd1);
        n_iss = 0;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            n_iss += int'(b_iv);
        end
        chk("flush.B_no_issue", 32'(n_iss), 32'd0);
        sx = pk(11, -11, 6, -6);
        step(1'b1, sx, 1'b0, 1'b0);
        idle(1);
        chk("flush.B_fresh_issue", 32'(b_iv), 32'd1);
        chk("flush.B_fresh_data", 32'({b_i3, b_i2, b_i1, b_i0}), 32'(sx));

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 20'($urandom), ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 49) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
